stopwatch_ctrl: RTL and testbench

- Controller for the stopwatch display path: sequences four external BCD digit counters (MM:SS) from start/stop, lap and clear button pulses.
- Generates the 1 Hz count tick from the board clock and per-digit cascade enables.
- Issues the shared clear command to all counters.
- Holds a lap snapshot and drives the digit values seen by the 7-segment driver.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_ctrl_tick_gen.sv | 43 ++++
 rtl/stopwatch_ctrl.sv | 128 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: FSM states, counter commands,
// digit limits.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_LAP   = 2'd2;
   localparam logic [1:0] ST_PAUSE = 2'd3;

   localparam logic [2:0] CMD_HOLD  = 3'd0;
   localparam logic [2:0] CMD_COUNT = 3'd1;
   localparam logic [2:0] CMD_CLEAR = 3'd2;

   // Highest value of a 0-9 digit and of a 0-5 (tens of seconds/minutes) digit
   localparam logic [3:0] DIGIT_MAX9 = 4'd9;
   localparam logic [3:0] DIGIT_MAX5 = 4'd5;

   // Steady-state command for a given FSM state
   function automatic logic [2:0] state_cmd(input logic [1:0] st);
      return (st == ST_RUN || st == ST_LAP) ? CMD_COUNT : CMD_HOLD;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler producing a one-cycle registered tick every TICK_DIV clocks while
// run is high. The count is held while run is low so a resumed run finishes the
// partial second; zero discards it.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned TICK_W   = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic zero,
   output logic tick
);

   localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] cnt_q;
   logic              tick_q;

   // Prescaler and tick register; zero takes precedence over run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (zero) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (run) begin
         if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
         end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
         end
      end else begin
         tick_q <= 1'b0;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM, counter command broadcast,
// MM:SS cascade enables, rollover pulse and lap snapshot display mux.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned TICK_W   = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic [3:0] sec_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] min_tens,
   output logic [2:0] cmd,
   output logic       en_so,
   output logic       en_st,
   output logic       en_mo,
   output logic       en_mt,
   output logic [3:0] disp_so,
   output logic [3:0] disp_st,
   output logic [3:0] disp_mo,
   output logic [3:0] disp_mt,
   output logic [1:0] state,
   output logic       ovf
);

   logic [1:0]  state_q, state_d;
   logic [2:0]  cmd_q, cmd_d;
   logic [15:0] snap_q, snap_d;
   logic        frozen_q, frozen_d;
   logic        clr_ok;
   logic        snap_cap;
   logic        tick;
   logic        counting;
   logic [15:0] live;

   assign live = {min_tens, min_ones, sec_tens, sec_ones};

   // Clear is honoured only while stopped
   assign clr_ok = btn_clr && (state_q == ST_IDLE || state_q == ST_PAUSE);

   // Next state; btn_clr masks the other buttons even when it is itself ignored
   always_comb begin
      state_d  = state_q;
      snap_cap = 1'b0;
      if (btn_clr) begin
         if (clr_ok) state_d = ST_IDLE;
      end else if (btn_ss) begin
         unique case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_LAP:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
         endcase
      end else if (btn_lap) begin
         case (state_q)
            ST_RUN: begin
               state_d  = ST_LAP;
               snap_cap = 1'b1;
            end
            ST_LAP:  state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // Command, snapshot and display-source selection for the next cycle
   always_comb begin
      cmd_d    = clr_ok ? CMD_CLEAR : state_cmd(state_d);
      snap_d   = snap_q;
      frozen_d = frozen_q;
      if (clr_ok) begin
         snap_d   = '0;
         frozen_d = 1'b0;
      end else begin
         if (snap_cap) snap_d = live;
         // Any entry to RUN shows live digits again, including resume from a
         // pause that was entered from LAP
         if (state_d == ST_LAP)      frozen_d = 1'b1;
         else if (state_d == ST_RUN) frozen_d = 1'b0;
      end
   end

   // Controller state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cmd_q    <= CMD_HOLD;
         snap_q   <= '0;
         frozen_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         snap_q   <= snap_d;
         frozen_q <= frozen_d;
      end
   end

   tick_gen #(
      .TICK_DIV (TICK_DIV),
      .TICK_W   (TICK_W)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .run  (state_q == ST_RUN || state_q == ST_LAP),
      .zero (state_q == ST_IDLE || clr_ok),
      .tick (tick)
   );

   // Cascade enables; a tick left over after leaving RUN is discarded by the cmd gate
   always_comb begin
      counting = (cmd_q == CMD_COUNT);
      en_so    = tick && counting;
      en_st    = en_so && (sec_ones == DIGIT_MAX9);
      en_mo    = en_st && (sec_tens == DIGIT_MAX5);
      en_mt    = en_mo && (min_ones == DIGIT_MAX9);
      ovf      = en_mt && (min_tens == DIGIT_MAX5);
   end

   assign {disp_mt, disp_mo, disp_st, disp_so} = frozen_q ? snap_q : live;
   assign cmd   = cmd_q;
   assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4 and a behavioural model of
// the four external BCD counters.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
   logic [3:0] so, st, mo, mt;
   logic [2:0] cmd;
   logic       en_so, en_st, en_mo, en_mt;
   logic [3:0] disp_so, disp_st, disp_mo, disp_mt;
   logic [1:0] state;
   logic       ovf;

   logic        preset_req = 1'b0;
   logic [15:0] preset_val = '0;

   int n_vec = 0;
   int n_err = 0;

   stopwatch_ctrl #(
      .TICK_DIV (4),
      .TICK_W   (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_ss   (btn_ss),
      .btn_lap  (btn_lap),
      .btn_clr  (btn_clr),
      .sec_ones (so),
      .sec_tens (st),
      .min_ones (mo),
      .min_tens (mt),
      .cmd      (cmd),
      .en_so    (en_so),
      .en_st    (en_st),
      .en_mo    (en_mo),
      .en_mt    (en_mt),
      .disp_so  (disp_so),
      .disp_st  (disp_st),
      .disp_mo  (disp_mo),
      .disp_mt  (disp_mt),
      .state    (state),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // External digit counters: preset hook, CLEAR command, modulus wrap
   always @(posedge clk) begin
      if (rst) begin
         {mt, mo, st, so} <= '0;
      end else if (preset_req) begin
         {mt, mo, st, so} <= preset_val;
      end else if (cmd == 3'd2) begin
         {mt, mo, st, so} <= '0;
      end else begin
         if (en_so) so <= (so == 4'd9) ? 4'd0 : so + 4'd1;
         if (en_st) st <= (st == 4'd5) ? 4'd0 : st + 4'd1;
         if (en_mo) mo <= (mo == 4'd9) ? 4'd0 : mo + 4'd1;
         if (en_mt) mt <= (mt == 4'd5) ? 4'd0 : mt + 4'd1;
      end
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic clr, input logic ss, input logic lap);
      btn_clr = clr;
      btn_ss  = ss;
      btn_lap = lap;
      cycle(1);
      btn_clr = 1'b0;
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
   endtask

   task automatic preset(input logic [15:0] v);
      preset_val = v;
      preset_req = 1'b1;
      cycle(1);
      preset_req = 1'b0;
   endtask

   // Advance until en_so is seen, bounded
   task automatic wait_tick();
      int n = 0;
      do begin
         cycle(1);
         n++;
      end while (!en_so && n < 8);
      check_eq("tick_seen", 16'(en_so), 16'd1);
   endtask

   function automatic logic [15:0] disp();
      return {disp_mt, disp_mo, disp_st, disp_so};
   endfunction

   function automatic logic [15:0] ens();
      return {12'd0, en_mt, en_mo, en_st, en_so};
   endfunction

   initial begin
      int pulses;
      cycle(3);
      check_eq("rst_state", 16'(state), 16'd0);
      check_eq("rst_cmd", 16'(cmd), 16'd0);
      check_eq("rst_en", ens(), 16'h0);
      rst = 1'b0;
      cycle(1);
      check_eq("idle_disp", disp(), 16'h0000);
      check_eq("idle_ovf", 16'(ovf), 16'd0);

      // Start: tick every 4 cycles
      press(1'b0, 1'b1, 1'b0);
      check_eq("start_state", 16'(state), 16'd1);
      check_eq("start_cmd", 16'(cmd), 16'd1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1);
         if (en_so) pulses++;
      end
      check_eq("tick_count", 16'(pulses), 16'd3);
      cycle(1);
      check_eq("count_0003", disp(), 16'h0003);

      // 00:59 cascade
      wait_tick();
      preset(16'h0059);
      wait_tick();
      check_eq("en_0059", ens(), 16'h7);
      check_eq("ovf_0059", 16'(ovf), 16'd0);
      cycle(1);
      check_eq("wrap_0100", disp(), 16'h0100);

      // 59:59 rollover
      wait_tick();
      preset(16'h5959);
      wait_tick();
      check_eq("en_5959", ens(), 16'hF);
      check_eq("ovf_5959", 16'(ovf), 16'd1);
      cycle(1);
      check_eq("ovf_pulse_end", 16'(ovf), 16'd0);
      check_eq("wrap_0000", disp(), 16'h0000);

      // Lap snapshot held while counters advance
      wait_tick();
      preset(16'h0007);
      press(1'b0, 1'b0, 1'b1);
      check_eq("lap_state", 16'(state), 16'd2);
      check_eq("lap_cmd", 16'(cmd), 16'd1);
      check_eq("lap_disp", disp(), 16'h0007);
      cycle(8);
      check_eq("lap_hold", disp(), 16'h0007);
      press(1'b0, 1'b0, 1'b1);
      check_eq("unlap_state", 16'(state), 16'd1);
      check_eq("unlap_disp", disp(), 16'h0009);

      // Pause mid-second, resume finishes the partial second
      wait_tick();
      cycle(2);
      press(1'b0, 1'b1, 1'b0);
      check_eq("pause_state", 16'(state), 16'd3);
      check_eq("pause_cmd", 16'(cmd), 16'd0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1);
         if (ens() != 16'h0) pulses++;
      end
      check_eq("pause_no_en", 16'(pulses), 16'd0);
      check_eq("pause_disp", disp(), 16'h0010);
      press(1'b0, 1'b1, 1'b0);
      check_eq("resume_state", 16'(state), 16'd1);
      check_eq("resume_no_tick", 16'(en_so), 16'd0);
      cycle(1);
      check_eq("resume_tick", 16'(en_so), 16'd1);

      // Clear beats start/stop in PAUSE
      press(1'b0, 1'b1, 1'b0);
      check_eq("pause2_state", 16'(state), 16'd3);
      press(1'b1, 1'b1, 1'b0);
      check_eq("clr_state", 16'(state), 16'd0);
      check_eq("clr_cmd", 16'(cmd), 16'd2);
      cycle(1);
      check_eq("clr_cmd_end", 16'(cmd), 16'd0);
      check_eq("clr_disp", disp(), 16'h0000);

      // Clear ignored while running
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      check_eq("clr_run_state", 16'(state), 16'd1);
      check_eq("clr_run_cmd", 16'(cmd), 16'd1);

      // LAP -> PAUSE keeps the snapshot, clear drops it
      wait_tick();
      preset(16'h0042);
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b0);
      check_eq("lap_pause_state", 16'(state), 16'd3);
      preset(16'h0013);
      check_eq("lap_pause_disp", disp(), 16'h0042);
      press(1'b1, 1'b0, 1'b0);
      check_eq("clr2_cmd", 16'(cmd), 16'd2);
      cycle(1);
      check_eq("clr2_state", 16'(state), 16'd0);
      check_eq("clr2_disp", disp(), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
